// File: rtl/fetch_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_pkg
// Shared ISA and fetch-FSM definitions used by the instruction-fetch front end.
//   OP_J / OP_JAL          : opcodes whose target is resolved at fetch time
//   OPCODE_MSB/OPCODE_LSB  : opcode field position, instr[31:27]
//   TARGET_MSB/TARGET_LSB  : jump-target field position, instr[26:0]
//   fetch_state_e          : fetch FSM state encoding
//   opcode_of()            : extracts the opcode field from a 32-bit word
//   is_jump()              : true for opcodes that redirect fetch by themselves
// -----------------------------------------------------------------------------
package fetch_sequencer_pkg;

    localparam logic [4:0] OP_J   = 5'b00001;
    localparam logic [4:0] OP_JAL = 5'b00011;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 27;
    localparam int TARGET_MSB = 26;
    localparam int TARGET_LSB = 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } fetch_state_e;

    function automatic logic [4:0] opcode_of(input logic [31:0] word);
        return word[OPCODE_MSB:OPCODE_LSB];
    endfunction

    function automatic logic is_jump(input logic [4:0] opcode);
        return (opcode == OP_J) || (opcode == OP_JAL);
    endfunction

endpackage

// File: rtl/fetch_sequencer_instr_fifo.sv
// -----------------------------------------------------------------------------
// instr_fifo
// Circular instruction buffer with head/tail pointers and an occupancy count.
// Parameters: DEPTH (power of two, >= 2), WIDTH (entry width in bits).
// Ports:
//   clock      in  : rising-edge clock
//   reset      in  : synchronous, active-low
//   push       in  : write push_data at the tail (ignored when full)
//   push_data  in  : entry to write
//   pop        in  : retire the head entry (ignored when empty)
//   flush      in  : drop every entry; wins over push and pop
//   count      out : number of valid entries, 0..DEPTH
//   head_data  out : registered contents of the head slot
// -----------------------------------------------------------------------------
module instr_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 44,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Pointer and count update. DEPTH is a power of two, so the pointers wrap
    // on their own. A flush only resets the bookkeeping; stale storage is
    // unreachable once count is zero.
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        do_push = push && (count_q != CNT_W'(DEPTH));
        do_pop  = pop && (count_q != '0);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) begin
                mem_d[tail_q] = push_data;
                tail_d        = tail_q + PTR_W'(1);
            end
            if (do_pop) begin
                head_d = head_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Storage is cleared on reset so the decode-side outputs read as zero.
    always_ff @(posedge clock) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign count     = count_q;
    assign head_data = mem_q[head_q];

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Instruction-fetch front end: issues one imem request at a time, buffers the
// returned words in program order for decode, follows j/jal at fetch time and
// accepts redirects from execute.
// Parameters: ADDR_W (pc width), BUF_DEPTH (buffer entries), RESET_PC.
// Ports:
//   clock, reset                      : clock; synchronous active-low reset
//   imem_req_valid/ready, imem_addr   : request channel to instruction memory
//   imem_rsp_valid, imem_rsp_data     : response channel from instruction memory
//   redirect_valid, redirect_pc       : single-cycle pc change from execute
//   instr_valid/ready, instr, instr_pc: buffer head presented to decode
//   fetch_opcode                      : instr[31:27] for the control decoder
// -----------------------------------------------------------------------------
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int                ADDR_W    = 12,
    parameter int                BUF_DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [4:0]        fetch_opcode
);

    localparam int CNT_W   = $clog2(BUF_DEPTH) + 1;
    localparam int ENTRY_W = 32 + ADDR_W;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] jump_pc;
    logic [ADDR_W-1:0] next_pc;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_flush;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  fill_after_push;
    logic [ENTRY_W-1:0] fifo_head;

    instr_fifo #(
        .DEPTH(BUF_DEPTH),
        .WIDTH(ENTRY_W)
    ) u_instr_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (fifo_push),
        .push_data({imem_rsp_data, pc_q}),
        .pop      (fifo_pop),
        .flush    (fifo_flush),
        .count    (fifo_count),
        .head_data(fifo_head)
    );

    // Next fetch address once the word at pc_q arrives. The jump target is
    // simply the low ADDR_W bits of the target field; sequential fetch wraps.
    always_comb begin
        seq_pc  = pc_q + ADDR_W'(1);
        jump_pc = imem_rsp_data[TARGET_LSB +: ADDR_W];
        next_pc = is_jump(opcode_of(imem_rsp_data)) ? jump_pc : seq_pc;
    end

    // Occupancy after this cycle's push and pop, used to decide whether
    // another request can be issued straight away without overrunning the
    // buffer. A pop only happens when the buffer is non-empty, so this never
    // underflows.
    assign fifo_pop        = instr_valid && instr_ready;
    assign fill_after_push = fifo_count + CNT_W'(1) - CNT_W'(fifo_pop);

    // Fetch FSM. Only one request is ever outstanding, so a pc register is
    // enough to tag the returning word. A redirect overrides everything:
    // it flushes the buffer and, if a response is still on its way, parks
    // in S_DRAIN to swallow it. When the stale response arrives in the same
    // cycle as the redirect, nothing is left in flight and fetch restarts.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (fifo_count < CNT_W'(BUF_DEPTH)) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    fifo_push = 1'b1;
                    pc_d      = next_pc;
                    state_d   = (fill_after_push < CNT_W'(BUF_DEPTH)) ? S_REQ : S_IDLE;
                end
            end
            S_DRAIN: begin
                if (imem_rsp_valid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (redirect_valid) begin
            fifo_flush = 1'b1;
            fifo_push  = 1'b0;
            pc_d       = redirect_pc;
            if (((state_q == S_WAIT) || (state_q == S_DRAIN)) && !imem_rsp_valid) begin
                state_d = S_DRAIN;
            end else begin
                state_d = S_REQ;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // All decode-facing outputs come straight from registers.
    assign imem_req_valid = (state_q == S_REQ);
    assign imem_addr      = pc_q;
    assign instr_valid    = (fifo_count != '0);
    assign instr          = fifo_head[ENTRY_W-1:ADDR_W];
    assign instr_pc       = fifo_head[ADDR_W-1:0];
    assign fetch_opcode   = opcode_of(instr);

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
// Drives fetch_sequencer with directed scenarios and then randomized traffic.
// A transaction-level model (expected decode queue, next-fetch pc, one
// in-flight request flag) is compared with the DUT at every falling edge.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

    localparam int          ADDR_W   = 12;
    localparam int          DEPTH    = 2;
    localparam logic [11:0] RESET_PC = 12'h000;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [11:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [11:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [11:0] instr_pc;
    logic [4:0]  fetch_opcode;

    always #5 clock = ~clock;

    fetch_sequencer #(
        .ADDR_W   (ADDR_W),
        .BUF_DEPTH(DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr     (imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .fetch_opcode  (fetch_opcode)
    );

    typedef struct packed {
        logic [11:0] pc;
        logic [31:0] data;
    } entry_t;

    // Reference model state: words decode must see, the pc fetch must use
    // next, and whether a request is in flight and still wanted.
    entry_t      exp_q[$];
    logic [11:0] model_pc;
    bit          outstanding;
    bit          out_live;
    logic [11:0] out_addr;

    // Instruction memory model with a configurable response delay.
    logic [31:0] mem_words [4096];
    bit          mem_pending;
    int          mem_delay;
    logic [11:0] mem_addr_pend;
    logic [11:0] rsp_addr_cur;

    logic [11:0] acc_log[$];
    logic [11:0] pop_log[$];
    int          n_cmp = 0;
    int          n_mis = 0;
    int          pops_total = 0;

    int          p_ready = 100;
    int          p_iready = 100;
    int          p_redirect = 0;
    int          p_reset = 0;
    int          lat_min = 0;
    int          lat_max = 0;
    bit          hold_reset = 1'b0;
    bit          force_redir = 1'b0;
    logic [11:0] force_pc = 12'h000;
    bit          redir_on_rsp = 1'b0;
    bit          redir_fired = 1'b0;
    logic [11:0] watch_addr = 12'h000;
    logic [11:0] watch_target = 12'h000;

    // The architectural next-pc rule: j/jal jump to the low 12 target bits,
    // everything else falls through with 12-bit wrap.
    function automatic logic [11:0] model_next_pc(input logic [11:0] pc, input logic [31:0] word);
        logic [4:0] op;
        op = word[31:27];
        if (op == 5'b00001 || op == 5'b00011) begin
            return word[11:0];
        end
        return pc + 12'd1;
    endfunction

    function automatic logic [31:0] log_at(input logic [11:0] q[$], input int idx);
        if (idx < q.size()) begin
            return {20'h0, q[idx]};
        end
        return 32'hFFFF_FFFF;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_mis++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Every-cycle comparison of the DUT against the model.
    task automatic compareModel();
        checkOutput("instr_valid", 32'(instr_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            checkOutput("instr_pc", 32'(instr_pc), 32'(exp_q[0].pc));
            checkOutput("instr", instr, exp_q[0].data);
            checkOutput("fetch_opcode", 32'(fetch_opcode), 32'(exp_q[0].data[31:27]));
        end
        checkOutput("imem_addr", 32'(imem_addr), 32'(model_pc));
        if (imem_req_valid) begin
            checkOutput("req_legal", {30'h0, outstanding, (exp_q.size() >= DEPTH)}, 32'h0);
        end
    endtask

    // Chooses inputs for the coming rising edge, including the memory reply.
    task automatic applyStimulus();
        reset = 1'b1;
        if (hold_reset || (int'($urandom_range(999, 0)) < p_reset)) begin
            reset = 1'b0;
        end
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if (mem_pending) begin
            if (mem_delay == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_words[mem_addr_pend];
                rsp_addr_cur   = mem_addr_pend;
                mem_pending    = 1'b0;
            end else begin
                mem_delay--;
            end
        end
        imem_req_ready = int'($urandom_range(99, 0)) < p_ready;
        instr_ready    = int'($urandom_range(99, 0)) < p_iready;
        redirect_valid = 1'b0;
        redirect_pc    = 12'h000;
        if (force_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = force_pc;
            force_redir    = 1'b0;
        end else if (redir_on_rsp && imem_rsp_valid && rsp_addr_cur == watch_addr) begin
            redirect_valid = 1'b1;
            redirect_pc    = watch_target;
            redir_on_rsp   = 1'b0;
            redir_fired    = 1'b1;
        end else if (int'($urandom_range(999, 0)) < p_redirect) begin
            redirect_valid = 1'b1;
            if ($urandom_range(3, 0) == 0) begin
                redirect_pc = 12'hFF0 | 12'($urandom_range(15, 0));
            end else begin
                redirect_pc = 12'($urandom_range(4095, 0));
            end
        end
    endtask

    // Advances the model by the transaction that the coming edge performs.
    task automatic modelStep();
        bit     pop;
        bit     accept;
        entry_t e;
        pop    = (exp_q.size() != 0) && instr_ready;
        accept = imem_req_valid && imem_req_ready && !redirect_valid;
        if (!reset) begin
            exp_q.delete();
            outstanding = 1'b0;
            out_live    = 1'b0;
            model_pc    = RESET_PC;
            mem_pending = 1'b0;
        end else if (redirect_valid) begin
            exp_q.delete();
            model_pc = redirect_pc;
            if (outstanding) begin
                if (imem_rsp_valid) begin
                    outstanding = 1'b0;
                end else begin
                    out_live = 1'b0;
                end
            end
        end else begin
            if (pop) begin
                pop_log.push_back(exp_q[0].pc);
                void'(exp_q.pop_front());
                pops_total++;
            end
            if (imem_rsp_valid && outstanding) begin
                if (out_live) begin
                    e.pc   = out_addr;
                    e.data = imem_rsp_data;
                    exp_q.push_back(e);
                    model_pc = model_next_pc(out_addr, imem_rsp_data);
                end
                outstanding = 1'b0;
            end
            if (accept) begin
                outstanding   = 1'b1;
                out_live      = 1'b1;
                out_addr      = imem_addr;
                acc_log.push_back(imem_addr);
                mem_pending   = 1'b1;
                mem_delay     = int'($urandom_range(lat_max, lat_min));
                mem_addr_pend = imem_addr;
            end
        end
    endtask

    task automatic runCycle();
        @(negedge clock);
        compareModel();
        applyStimulus();
        modelStep();
    endtask

    task automatic doReset();
        hold_reset = 1'b1;
        runCycle();
        runCycle();
        hold_reset = 1'b0;
        acc_log.delete();
        pop_log.delete();
    endtask

    task automatic fillAdds();
        for (int i = 0; i < 4096; i++) begin
            mem_words[i] = {5'b00000, 15'h1234, 12'(i)};
        end
    endtask

    task automatic fillRandom();
        logic [4:0] op;
        int         r;
        for (int i = 0; i < 4096; i++) begin
            r  = int'($urandom_range(9, 0));
            op = 5'($urandom_range(31, 0));
            if (op == 5'b00001 || op == 5'b00011) begin
                op = 5'b00000;
            end
            if (r == 0) begin
                op = 5'b00001;
            end else if (r == 1) begin
                op = 5'b00011;
            end
            mem_words[i] = {op, 27'($urandom)};
        end
    endtask

    task automatic setLat(input int lo, input int hi);
        lat_min = lo;
        lat_max = hi;
    endtask

    // Hard stop in case anything above blocks forever.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not reach the end");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by randomized traffic; a single process
    // owns stimulus, the model and all comparisons.
    initial begin
        bit found;
        int pops_start;

        reset          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 12'h000;
        instr_ready    = 1'b0;
        model_pc       = RESET_PC;
        outstanding    = 1'b0;
        out_live       = 1'b0;
        out_addr       = 12'h000;
        mem_pending    = 1'b0;
        mem_delay      = 0;
        mem_addr_pend  = 12'h000;
        rsp_addr_cur   = 12'h000;
        fillAdds();
        repeat (2) @(posedge clock);

        // Reset values, first request timing and sequential throughput.
        $display("[TB] reset release and sequential fetch");
        setLat(0, 0);
        doReset();
        checkOutput("rst_req_valid", 32'(imem_req_valid), 32'h0);
        checkOutput("rst_instr_valid", 32'(instr_valid), 32'h0);
        checkOutput("rst_imem_addr", 32'(imem_addr), 32'(RESET_PC));
        checkOutput("rst_instr", instr, 32'h0);
        checkOutput("rst_instr_pc", 32'(instr_pc), 32'h0);
        checkOutput("rst_opcode", 32'(fetch_opcode), 32'h0);
        runCycle();
        runCycle();
        checkOutput("first_req_valid", 32'(imem_req_valid), 32'h1);
        checkOutput("first_req_instr_valid", 32'(instr_valid), 32'h0);
        runCycle();
        checkOutput("cycle2_instr_valid", 32'(instr_valid), 32'h0);
        runCycle();
        checkOutput("cycle3_instr_valid", 32'(instr_valid), 32'h1);
        checkOutput("cycle3_instr_pc", 32'(instr_pc), 32'h000);
        repeat (8) runCycle();
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("seq_acc%0d", i), log_at(acc_log, i), 32'(i));
            checkOutput($sformatf("seq_pop%0d", i), log_at(pop_log, i), 32'(i));
        end

        // j at pc 5 goes straight to 0x040 with no fetch of 6.
        $display("[TB] jump resolved at fetch");
        mem_words[5] = {5'b00001, 27'h0000040};
        doReset();
        force_redir = 1'b1;
        force_pc    = 12'h005;
        repeat (12) runCycle();
        checkOutput("j_acc0", log_at(acc_log, 0), 32'h005);
        checkOutput("j_acc1", log_at(acc_log, 1), 32'h040);
        checkOutput("j_acc2", log_at(acc_log, 2), 32'h041);
        checkOutput("j_pop0", log_at(pop_log, 0), 32'h005);
        checkOutput("j_pop1", log_at(pop_log, 1), 32'h040);
        fillAdds();

        // Decode stalled: only BUF_DEPTH requests, then one per freed slot.
        $display("[TB] back-pressure from decode");
        p_iready = 0;
        doReset();
        repeat (10) runCycle();
        checkOutput("stall_acc_count", 32'(acc_log.size()), 32'd2);
        checkOutput("stall_req_valid", 32'(imem_req_valid), 32'h0);
        checkOutput("stall_instr_valid", 32'(instr_valid), 32'h1);
        p_iready = 100;
        runCycle();
        p_iready = 0;
        repeat (6) runCycle();
        checkOutput("release_acc_count", 32'(acc_log.size()), 32'd3);
        checkOutput("release_pop_count", 32'(pop_log.size()), 32'd1);
        checkOutput("release_pop0", log_at(pop_log, 0), 32'(RESET_PC));
        checkOutput("release_req_valid", 32'(imem_req_valid), 32'h0);
        p_iready = 100;

        // Redirect while a slow response is in flight: it must be drained.
        $display("[TB] redirect with response in flight");
        setLat(3, 3);
        doReset();
        force_redir = 1'b1;
        force_pc    = 12'h007;
        found       = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            runCycle();
            if (acc_log.size() != 0 && acc_log[acc_log.size()-1] == 12'h007) begin
                found = 1'b1;
            end
        end
        checkOutput("wait_acc_007", 32'(found), 32'h1);
        acc_log.delete();
        pop_log.delete();
        force_redir = 1'b1;
        force_pc    = 12'h100;
        repeat (16) runCycle();
        checkOutput("drain_acc0", log_at(acc_log, 0), 32'h100);
        checkOutput("drain_pop0", log_at(pop_log, 0), 32'h100);

        // Redirect coinciding with the response: no drain, request next cycle.
        $display("[TB] redirect together with response");
        setLat(2, 2);
        doReset();
        force_redir  = 1'b1;
        force_pc     = 12'h009;
        redir_on_rsp = 1'b1;
        redir_fired  = 1'b0;
        watch_addr   = 12'h009;
        watch_target = 12'h020;
        for (int i = 0; i < 20 && !redir_fired; i++) begin
            runCycle();
        end
        checkOutput("wait_rsp_009", 32'(redir_fired), 32'h1);
        redir_on_rsp = 1'b0;
        pop_log.delete();
        runCycle();
        checkOutput("same_cycle_req_valid", 32'(imem_req_valid), 32'h1);
        checkOutput("same_cycle_req_addr", 32'(imem_addr), 32'h020);
        repeat (10) runCycle();
        checkOutput("same_cycle_pop0", log_at(pop_log, 0), 32'h020);

        // pc wrap at the top of the address space, then reset mid-stream.
        $display("[TB] pc wrap and mid-stream reset");
        setLat(0, 0);
        doReset();
        force_redir = 1'b1;
        force_pc    = 12'hFFF;
        repeat (10) runCycle();
        checkOutput("wrap_acc0", log_at(acc_log, 0), 32'hFFF);
        checkOutput("wrap_acc1", log_at(acc_log, 1), 32'h000);
        checkOutput("wrap_pop1", log_at(pop_log, 1), 32'h000);
        hold_reset = 1'b1;
        runCycle();
        hold_reset = 1'b0;
        acc_log.delete();
        runCycle();
        checkOutput("midrst_instr_valid", 32'(instr_valid), 32'h0);
        checkOutput("midrst_req_valid", 32'(imem_req_valid), 32'h0);
        checkOutput("midrst_imem_addr", 32'(imem_addr), 32'(RESET_PC));
        repeat (8) runCycle();
        checkOutput("midrst_refetch", log_at(acc_log, 0), 32'(RESET_PC));

        // Randomized traffic against the model.
        $display("[TB] randomized traffic");
        fillRandom();
        doReset();
        pops_start = pops_total;
        for (int blk = 0; blk < 15; blk++) begin
            p_ready    = int'($urandom_range(100, 30));
            p_iready   = int'($urandom_range(100, 20));
            p_redirect = 30;
            p_reset    = 2;
            setLat(0, int'($urandom_range(3, 0)));
            repeat (200) runCycle();
        end
        checkOutput("random_progress", 32'(pops_total - pops_start >= 100), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch front end for the single-issue core. Generates word addresses into instruction memory over a valid/ready request channel and accepts responses. Buffers fetched words and presents them, in program order, to the decode stage, whose opcode field drives the control decoder. Resolves `j` and `jal` targets at fetch time; accepts taken-branch, `jr` and `bex` redirects from execute.

## Interface
- `ADDR_W`, default 12: PC / imem word-address width.
- `BUF_DEPTH`, default 2: instruction buffer entries; power of two, minimum 2.
- `RESET_PC`, default 0: first fetch address after reset.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low; while 0 at a rising edge, all state returns to reset values.
- `imem_req_valid` out 1: request pending.
- `imem_req_ready` in 1: imem accepts the request this cycle.
- `imem_addr` out ADDR_W: word address of the request.
- `imem_rsp_valid` in 1: response word present this cycle.
- `imem_rsp_data` in 32: instruction word.
- `redirect_valid` in 1: execute orders a PC change; single-cycle pulse.
- `redirect_pc` in ADDR_W: new fetch address.
- `instr_valid` out 1: buffer head is valid.
- `instr_ready` in 1: decode consumes the head this cycle.
- `instr` out 32: head instruction word.
- `instr_pc` out ADDR_W: address of the head instruction.
- `fetch_opcode` out 5: `instr[31:27]`, feeding the control decoder.

## Operation
- FSM states: `S_IDLE`, `S_REQ`, `S_WAIT`, `S_DRAIN`.
- `S_IDLE`: move to `S_REQ` when credits are available; credits = BUF_DEPTH − occupancy.
- `S_REQ`: assert `imem_req_valid` with `imem_addr = pc`. On `imem_req_ready`, go to `S_WAIT`. Hold `imem_addr` stable until accepted.
- `S_WAIT`: at most one request is outstanding. On `imem_rsp_valid`:
  - write `{data, pc}` into the buffer;
  - compute next pc (rules below);
  - go to `S_REQ` if a credit remains, else `S_IDLE`.
- Next-pc rules:
  - opcode 00001 (`j`) or 00011 (`jal`): next pc = `data[ADDR_W-1:0]`, with the target truncated to ADDR_W.
  - any other opcode: next pc = pc + 1, modulo 2^ADDR_W; 2^ADDR_W−1 wraps to 0.
- Redirect, taken in any state:
  - flush the buffer (occupancy becomes 0) and set pc = `redirect_pc`.
  - If a request was accepted and its response has not arrived, go to `S_DRAIN`. Otherwise go to `S_REQ`.
- `S_DRAIN`: discard the next response without buffering it, then go to `S_REQ`. A further redirect while in `S_DRAIN` updates pc and stays in `S_DRAIN`.
- Redirect during `S_REQ` before acceptance: the request retargets immediately. The redirect takes priority over `imem_req_ready` in the same cycle; that handshake is not counted as accepted.
- Buffer: circular FIFO with head/tail pointers and a count.
  - `instr_valid` = count ≠ 0.
  - Pop on `instr_valid & instr_ready`.
  - Push and pop in the same cycle leave the count unchanged.
- Simultaneous events:
  - redirect and `imem_rsp_valid` in the same cycle: the response is discarded and the FSM goes to `S_REQ` (not `S_DRAIN`);
  - redirect and pop in the same cycle: the flush wins.
- Reset values:
  - pc = RESET_PC, state `S_IDLE`, count 0, stale flag 0;
  - all outputs 0, except `imem_addr` = RESET_PC.
- Reset mid-operation: the in-flight response is the environment's responsibility; the memory model must also be reset.

## Timing
- Request-to-buffer latency: response cycle + 1; `instr_valid` rises the cycle after `imem_rsp_valid`.
- Zero-wait-state imem with `instr_ready` = 1: one instruction every 2 cycles (REQ, WAIT), since there is no request pipelining.
- Redirect-to-new-request: the next cycle when nothing is outstanding. Otherwise the cycle after the stale response.
- First request after reset release: 2 cycles (`S_IDLE` → `S_REQ`).
- `instr`, `instr_pc` and `fetch_opcode` come directly from buffer registers, with no combinational path from imem.

## Structure
- The shared ISA package holds:
  - opcode constants `OP_J` = 5'b00001 and `OP_JAL` = 5'b00011;
  - field slices opcode [31:27] and target [26:0];
  - FSM state encoding.
- One sub-module, `instr_fifo`: parameterised depth and width (32 + ADDR_W), with push, pop, flush and count.
- The FSM, pc register and next-pc logic live in `fetch_sequencer`.

## Test plan
- Reset release, zero-wait imem returning `add` words, `instr_ready` = 1: addresses 0,1,2,3 issued; `instr_pc` sequence 0,1,2,3; `instr_valid` first high in cycle 3.
- Word at pc 5 = `j` with target 0x040: next `imem_addr` is 0x040. `instr_pc` sequence is 5, then 0x040; no fetch of 6.
- `instr_ready` held 0 for 10 cycles: exactly BUF_DEPTH = 2 requests issued, then `imem_req_valid` = 0. On release, the head pops and one new request issues.
- imem with 3-cycle latency, redirect to 0x100 one cycle after a request to 0x007 is accepted: the 0x007 response is dropped; the next accepted request is 0x100; `instr_valid` stays low until the 0x100 word arrives.
- Redirect to 0x020 in the same cycle as `imem_rsp_valid` for 0x009: 0x009 is never presented; the request to 0x020 issues the next cycle with no `S_DRAIN`.
- pc = 0xFFF, `ADDR_W` = 12: the next sequential request is 0x000. `reset` = 0 mid-stream clears `instr_valid` the next cycle and refetches from RESET_PC.
